fetch_queue: RTL and testbench

//  Instruction fetch buffer directly upstream of the dual-issue scheduling stage. Fetches 32-bit

---
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response, redirect, scheduler freezes and issue pair.
// master = fetch_queue side, slave = memory/scheduler side.
interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          freeze1;
    logic          freeze2;
    logic [31:0]   instruction0;
    logic [31:0]   instruction1;
    logic          valid0;
    logic          valid1;
    logic          nothing_filled;
    logic [CW-1:0] count;

    modport master (
        output mem_req, mem_addr, instruction0, instruction1,
               valid0, valid1, nothing_filled, count,
        input  mem_rvalid, mem_rdata, redirect, redirect_pc, freeze1, freeze2
    );

    modport slave (
        input  mem_req, mem_addr, instruction0, instruction1,
               valid0, valid1, nothing_filled, count,
        output mem_rvalid, mem_rdata, redirect, redirect_pc, freeze1, freeze2
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch into a circular buffer, presenting the two oldest words as an issue pair.
// Latency: request registered one edge after IDLE decision; pushed word visible on the issue slots the edge after rvalid.
// Backpressure: fetch stalls while the buffer is full; freeze1/freeze2 throttle retirement; redirect flushes.
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  fq
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc;
    logic [31:0]   mem_addr;
    logic          mem_req;
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1;
    logic [CW-1:0] count;
    logic [31:0]   buf_mem [DEPTH];

    logic          issue;
    logic          push;
    logic [CW-1:0] want_n;
    logic [CW-1:0] pop_n;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        want_n    = fq.freeze1 ? '0 : (fq.freeze2 ? CW'(1) : CW'(2));
        pop_n     = (want_n > count) ? count : want_n;

        if (fq.redirect) begin
            // An in-flight request must still be drained, so it is tracked in DISCARD.
            case (state)
                WAIT, DISCARD: state_nxt = fq.mem_rvalid ? IDLE : DISCARD;
                default:       state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        issue     = 1'b1;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (fq.mem_rvalid) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DISCARD: begin
                    if (fq.mem_rvalid) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            mem_req <= issue;
            if (fq.redirect) begin
                pc     <= fq.redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (issue) begin
                    mem_addr <= pc;
                    pc       <= pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                rd_ptr <= rd_ptr + PW'(pop_n);
                count  <= count + CW'(push) - pop_n;
            end
        end
    end

    // Storage is deliberately left unreset; occupancy alone qualifies the slots.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= fq.mem_rdata;
        end
    end

    assign rd_ptr1 = rd_ptr + PW'(1);

    assign fq.mem_req        = mem_req;
    assign fq.mem_addr       = mem_addr;
    assign fq.count          = count;
    assign fq.valid0         = (count != '0);
    assign fq.valid1         = (count >= CW'(2));
    assign fq.nothing_filled = (count == '0);
    assign fq.instruction0   = fq.valid0 ? buf_mem[rd_ptr]  : NOP;
    assign fq.instruction1   = fq.valid1 ? buf_mem[rd_ptr1] : NOP;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue plus hand-written redirect and async-reset sequences.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W1  = 32'h0010_0093;
    localparam logic [31:0] W2  = 32'h0020_0113;
    localparam logic [31:0] W3  = 32'h0030_0193;
    localparam logic [31:0] W4  = 32'h0040_0213;
    localparam logic [31:0] W5  = 32'h0050_0293;
    localparam logic [31:0] W6  = 32'h0060_0313;
    localparam logic [31:0] W7  = 32'h0070_0393;
    localparam logic [31:0] W8  = 32'h0080_0413;
    localparam logic [31:0] W9  = 32'h0090_0493;
    localparam logic [31:0] W10 = 32'h00A0_0513;
    localparam logic [31:0] W11 = 32'h00B0_0593;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(8)) fq ();

    fetch_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    typedef struct {
        logic        f1;
        logic        f2;
        logic        rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  cnt;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic f1, input logic f2, input logic rv, input logic [31:0] rd,
                       input logic req, input logic [31:0] addr, input logic [3:0] cnt,
                       input logic [31:0] i0, input logic [31:0] i1);
        vec_t v;
        v.f1 = f1; v.f2 = f2; v.rv = rv; v.rd = rd;
        v.req = req; v.addr = addr; v.cnt = cnt; v.i0 = i0; v.i1 = i1;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [3:0] cnt, input logic [31:0] i0, input logic [31:0] i1);
        chk({tag, " mem_req"},        32'(fq.mem_req),        32'(req));
        chk({tag, " mem_addr"},       fq.mem_addr,            addr);
        chk({tag, " count"},          32'(fq.count),          32'(cnt));
        chk({tag, " valid0"},         32'(fq.valid0),         32'(cnt >= 4'd1));
        chk({tag, " valid1"},         32'(fq.valid1),         32'(cnt >= 4'd2));
        chk({tag, " nothing_filled"}, 32'(fq.nothing_filled), 32'(cnt == 4'd0));
        chk({tag, " instruction0"},   fq.instruction0,        i0);
        chk({tag, " instruction1"},   fq.instruction1,        i1);
    endtask

    task automatic drive(input logic f1, input logic f2, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc);
        fq.freeze1     = f1;
        fq.freeze2     = f2;
        fq.mem_rvalid  = rv;
        fq.mem_rdata   = rd;
        fq.redirect    = redir;
        fq.redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill, stall at full, single pop, double pop with wrap, drain to empty with clamping.
        add(1,1,0,0,   1,32'h00,0,NOP,NOP);
        add(1,1,1,W1,  0,32'h00,1,W1,NOP);
        add(1,1,0,0,   1,32'h04,1,W1,NOP);
        add(1,1,1,W2,  0,32'h04,2,W1,W2);
        add(1,1,0,0,   1,32'h08,2,W1,W2);
        add(1,1,1,W3,  0,32'h08,3,W1,W2);
        add(1,1,0,0,   1,32'h0C,3,W1,W2);
        add(1,1,1,W4,  0,32'h0C,4,W1,W2);
        add(1,1,0,0,   1,32'h10,4,W1,W2);
        add(1,1,1,W5,  0,32'h10,5,W1,W2);
        add(1,1,0,0,   1,32'h14,5,W1,W2);
        add(1,1,1,W6,  0,32'h14,6,W1,W2);
        add(1,1,0,0,   1,32'h18,6,W1,W2);
        add(1,1,1,W7,  0,32'h18,7,W1,W2);
        add(1,1,0,0,   1,32'h1C,7,W1,W2);
        add(1,1,1,W8,  0,32'h1C,8,W1,W2);
        add(1,1,0,0,   0,32'h1C,8,W1,W2);
        add(1,1,0,0,   0,32'h1C,8,W1,W2);
        add(0,1,0,0,   0,32'h1C,7,W2,W3);
        add(1,1,0,0,   1,32'h20,7,W2,W3);
        add(0,0,1,W9,  0,32'h20,6,W4,W5);
        add(0,0,0,0,   1,32'h24,4,W6,W7);
        add(0,0,0,0,   0,32'h24,2,W8,W9);
        add(0,1,0,0,   0,32'h24,1,W9,NOP);
        add(0,0,0,0,   0,32'h24,0,NOP,NOP);
        add(0,0,0,0,   0,32'h24,0,NOP,NOP);
        add(0,0,1,W10, 0,32'h24,1,W10,NOP);

        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        chk_all("reset", 0, 32'h0, 0, NOP, NOP);
        tick();
        tick();
        chk_all("reset_held", 0, 32'h0, 0, NOP, NOP);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].f1, vq[i].f2, vq[i].rv, vq[i].rd, 0, 32'h0);
            tick();
            chk_all($sformatf("v%0d", i), vq[i].req, vq[i].addr, vq[i].cnt, vq[i].i0, vq[i].i1);
        end

        // Redirect while a request is outstanding: late response is dropped.
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        tick();
        chk_all("rd_issue", 1, 32'h28, 1, W10, NOP);
        drive(1, 1, 0, 32'h0, 1, 32'h100);
        tick();
        chk_all("rd_flush", 0, 32'h28, 0, NOP, NOP);
        drive(1, 1, 1, 32'hDEAD_BEEF, 0, 32'h0);
        tick();
        chk_all("rd_drop", 0, 32'h28, 0, NOP, NOP);
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        tick();
        chk_all("rd_newpc", 1, 32'h100, 0, NOP, NOP);
        drive(1, 1, 1, W11, 0, 32'h0);
        tick();
        chk_all("rd_fill", 0, 32'h100, 1, W11, NOP);

        // Asynchronous reset mid-WAIT, then a stale response after release.
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        tick();
        chk_all("ar_issue", 1, 32'h104, 1, W11, NOP);
        #3;
        rst = 1'b0;
        #1;
        chk_all("ar_async", 0, 32'h0, 0, NOP, NOP);
        tick();
        tick();
        rst = 1'b1;
        drive(1, 1, 1, 32'hDEAD_BEEF, 0, 32'h0);
        tick();
        chk_all("ar_stale", 1, 32'h0, 0, NOP, NOP);
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        tick();
        chk_all("ar_wait", 0, 32'h0, 0, NOP, NOP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
